// File: rtl/pll_rst_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_rst_seq_pkg : shared types and defaults for the PLL reset sequencer  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package pll_rst_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES         = 2;
   localparam int DEF_PLL_RST_CYCLES      = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int DEF_STAGE_GAP_CYCLES    = 16;
   localparam int DEF_LOSS_FILTER_CYCLES  = 4;
   localparam int DEF_CNT_W               = 20;

   localparam logic [7:0] RELOCK_MAX = 8'd255;

   function automatic logic [7:0] relock_inc(input logic [7:0] val);
      return (val == RELOCK_MAX) ? val : val + 8'd1;
   endfunction

endpackage : pll_rst_seq_pkg
`default_nettype wire

// File: rtl/pll_rst_seq_lock_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_lock_sync : multi-flop synchroniser for the asynchronous PLL lock    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pll_lock_sync
   import pll_rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic lock_s
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

endmodule : pll_lock_sync
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_rst_seq : PLL reset/lock sequencer with staged periph/core release.  |
// | Optional lock timeout retry enabled by macro PLL_RST_SEQ_TIMEOUT_EN.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pll_rst_seq
   import pll_rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
   parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
   parameter int LOSS_FILTER_CYCLES  = DEF_LOSS_FILTER_CYCLES,
   parameter int CNT_W               = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   output logic       pll_rst,
   output logic       periph_rst,
   output logic       core_rst,
   output logic       sys_ready,
   output logic [7:0] relock_cnt
);

   if ((SYNC_STAGES < 2) || (PLL_RST_CYCLES < 1) || (LOCK_STABLE_CYCLES < 1) ||
       (LOCK_TIMEOUT_CYCLES < 1) || (STAGE_GAP_CYCLES < 1) || (LOSS_FILTER_CYCLES < 1) ||
       (PLL_RST_CYCLES > 2**CNT_W) || (LOCK_STABLE_CYCLES > 2**CNT_W) ||
       (LOCK_TIMEOUT_CYCLES > 2**CNT_W) || (STAGE_GAP_CYCLES > 2**CNT_W) ||
       (LOSS_FILTER_CYCLES > 2**CNT_W)) begin : g_param_check
      $error("pll_rst_seq: parameter out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER_CYCLES - 1);

   logic             lock_s;
   state_t           state_q,      state_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic [7:0]       relock_q,     relock_d;
   logic             pll_rst_q,    pll_rst_d;
   logic             periph_rst_q, periph_rst_d;
   logic             core_rst_q,   core_rst_d;
   logic             sys_ready_q,  sys_ready_d;
   logic             relock_evt;
   logic             timeout_hit;

   pll_lock_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (pll_lock),
      .lock_s   (lock_s)
   );

`ifdef PLL_RST_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tcnt_q, tcnt_d;

   always_comb begin
      timeout_hit = (state_q == WAIT_LOCK) && (tcnt_q == TIMEOUT_LAST);
      // Runs only while WAIT_LOCK persists, so any state change restarts it.
      tcnt_d      = ((state_q == WAIT_LOCK) && (state_d == WAIT_LOCK)) ? tcnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      relock_evt = 1'b0;

      case (state_q)
         PLL_RST: begin
            if (cnt_q == PLL_RST_LAST) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (!lock_s) begin
               cnt_d = '0;
            end
            // Stable lock takes priority over a coincident timeout.
            if (lock_s && (cnt_q == STABLE_LAST)) begin
               state_d = RELEASE;
            end else if (timeout_hit) begin
               state_d    = PLL_RST;
               relock_evt = 1'b1;
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               state_d    = PLL_RST;
               relock_evt = 1'b1;
            end else if (cnt_q == GAP_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (lock_s) begin
               cnt_d = '0;
            end else if (cnt_q == LOSS_LAST) begin
               state_d    = PLL_RST;
               relock_evt = 1'b1;
            end
         end
         default: begin
            state_d = PLL_RST;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end

      relock_d = relock_evt ? relock_inc(relock_q) : relock_q;

      // Outputs are decoded from the next state so they change on the transition edge.
      pll_rst_d    = (state_d == PLL_RST);
      periph_rst_d = (state_d == PLL_RST) || (state_d == WAIT_LOCK);
      core_rst_d   = (state_d != RUN);
      sys_ready_d  = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= PLL_RST;
         cnt_q        <= '0;
         relock_q     <= '0;
         pll_rst_q    <= 1'b1;
         periph_rst_q <= 1'b1;
         core_rst_q   <= 1'b1;
         sys_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         relock_q     <= relock_d;
         pll_rst_q    <= pll_rst_d;
         periph_rst_q <= periph_rst_d;
         core_rst_q   <= core_rst_d;
         sys_ready_q  <= sys_ready_d;
      end
   end

   assign pll_rst    = pll_rst_q;
   assign periph_rst = periph_rst_q;
   assign core_rst   = core_rst_q;
   assign sys_ready  = sys_ready_q;
   assign relock_cnt = relock_q;

endmodule : pll_rst_seq
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pll_rst_seq : scoreboard bench with a phase/time reference model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pll_rst_seq;

   localparam int SYNC   = 2;
   localparam int PRC    = 16;
   localparam int STABLE = 24;
   localparam int TO     = 300;
   localparam int GAP    = 16;
   localparam int LF     = 4;

`ifdef PLL_RST_SEQ_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   localparam int P_PLL  = 0;
   localparam int P_WAIT = 1;
   localparam int P_REL  = 2;
   localparam int P_RUN  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_lock;
   logic       pll_rst, periph_rst, core_rst, sys_ready;
   logic [7:0] relock_cnt;

   typedef struct packed {
      logic       pll_rst;
      logic       periph_rst;
      logic       core_rst;
      logic       sys_ready;
      logic [7:0] relock;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: phase, time spent in phase, run lengths of the synced lock level.
   int   ph, t_in, run_hi, run_lo, relocks;
   bit   hist[$];

   pll_rst_seq #(
      .SYNC_STAGES         (SYNC),
      .PLL_RST_CYCLES      (PRC),
      .LOCK_STABLE_CYCLES  (STABLE),
      .LOCK_TIMEOUT_CYCLES (TO),
      .STAGE_GAP_CYCLES    (GAP),
      .LOSS_FILTER_CYCLES  (LF),
      .CNT_W               (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_lock   (pll_lock),
      .pll_rst    (pll_rst),
      .periph_rst (periph_rst),
      .core_rst   (core_rst),
      .sys_ready  (sys_ready),
      .relock_cnt (relock_cnt)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int min2(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_reset();
      ph = P_PLL; t_in = 0; run_hi = 0; run_lo = 0; relocks = 0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
   endfunction

   function automatic void lost();
      if (relocks < 255) relocks++;
   endfunction

   function automatic void model_step(bit lk);
      bit ls;
      int nph;
      ls = hist.pop_front();
      hist.push_back(lk);
      run_hi = ls ? run_hi + 1 : 0;
      run_lo = ls ? 0 : run_lo + 1;
      t_in++;
      nph = ph;
      case (ph)
         P_PLL:  if (t_in >= PRC) nph = P_WAIT;
         P_WAIT: begin
            if (min2(run_hi, t_in) >= STABLE) nph = P_REL;
            else if (TIMEOUT_ON && t_in >= TO) begin nph = P_PLL; lost(); end
         end
         P_REL: begin
            if (!ls) begin nph = P_PLL; lost(); end
            else if (t_in >= GAP) nph = P_RUN;
         end
         default: if (min2(run_lo, t_in) >= LF) begin nph = P_PLL; lost(); end
      endcase
      if (nph != ph) begin ph = nph; t_in = 0; end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.pll_rst    = (ph == P_PLL);
      e.periph_rst = (ph == P_PLL) || (ph == P_WAIT);
      e.core_rst   = (ph != P_RUN);
      e.sys_ready  = (ph == P_RUN);
      e.relock     = 8'(relocks);
      return e;
   endfunction

   task automatic tick(bit lk);
      pll_lock = lk;
      @(posedge clk);
      model_step(lk);
      sb_q.push_back(model_out());
      #1;
   endtask

   task automatic drive_until(int p, bit lk, int budget, string name);
      int n;
      n = 0;
      while (ph != p && n < budget) begin
         tick(lk);
         n++;
      end
      if (ph != p) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: phase %0d not reached, required %0d within %0d cycles", name, ph, p, budget);
      end
   endtask

   task automatic async_reset(string name);
      #2 rst = 1'b1;
      #1;
      check({name, "_pll_rst"},    32'(pll_rst),    32'd1);
      check({name, "_periph_rst"}, 32'(periph_rst), 32'd1);
      check({name, "_core_rst"},   32'(core_rst),   32'd1);
      check({name, "_sys_ready"},  32'(sys_ready),  32'd0);
      check({name, "_relock"},     32'(relock_cnt), 32'd0);
      sb_q.delete();
      model_reset();
      @(posedge clk);
      sb_q.push_back(model_out());
      #1 rst = 1'b0;
   endtask

   // Monitor: every cycle the DUT presents its output vector, compare against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("pll_rst",    32'(pll_rst),    32'(mon_e.pll_rst));
            check("periph_rst", 32'(periph_rst), 32'(mon_e.periph_rst));
            check("core_rst",   32'(core_rst),   32'(mon_e.core_rst));
            check("sys_ready",  32'(sys_ready),  32'(mon_e.sys_ready));
            check("relock_cnt", 32'(relock_cnt), 32'(mon_e.relock));
            check("core_before_periph", 32'(!core_rst && periph_rst), 32'd0);
            check("pll_rst_while_released", 32'(pll_rst && (!periph_rst || !core_rst)), 32'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seg_len;
      bit lvl;
      rst      = 1'b1;
      pll_lock = 1'b0;
      model_reset();
      repeat (2) begin
         @(posedge clk);
         sb_q.push_back(model_out());
      end
      #1 rst = 1'b0;

      // Lock absent: pll_rst pulse, then (without timeout) a quiet wait.
      repeat (TO + PRC + 40) tick(1'b0);
      drive_until(P_RUN, 1'b1, TO + 200, "first_lock");
      repeat (10) tick(1'b1);

      // Glitch one cycle shorter than the loss filter, then an exact-length loss.
      repeat (LF - 1) tick(1'b0);
      repeat (12) tick(1'b1);
      repeat (LF) tick(1'b0);
      drive_until(P_RUN, 1'b1, TO + 200, "relock_after_loss");

      // Lock drop five cycles into RELEASE.
      repeat (LF + 2) tick(1'b0);
      drive_until(P_REL, 1'b1, TO + 200, "reach_release");
      repeat (5 - SYNC) tick(1'b1);
      repeat (SYNC + 3) tick(1'b0);
      drive_until(P_RUN, 1'b1, TO + 200, "relock_after_release_drop");

      // Randomised lock waveform.
      lvl = 1'b1;
      repeat (400) begin
         if (lvl) seg_len = $urandom_range(1, 70);
         else if ($urandom_range(0, 9) < 7) seg_len = $urandom_range(1, LF + 2);
         else seg_len = $urandom_range(1, 40);
         repeat (seg_len) tick(lvl);
         lvl = !lvl;
      end

      // Asynchronous reset from WAIT_LOCK and from RUN.
      drive_until(P_WAIT, 1'b0, TO + 200, "reach_wait");
      repeat (3) tick(1'b0);
      async_reset("rst_in_wait");
      drive_until(P_RUN, 1'b1, TO + 200, "reach_run");
      repeat (3) tick(1'b1);
      async_reset("rst_in_run");

      // Repeated lock losses drive relock_cnt into saturation.
      repeat (300) begin
         drive_until(P_RUN, 1'b1, TO + 200, "loss_loop_run");
         repeat (LF + SYNC) tick(1'b0);
      end
      drive_until(P_RUN, 1'b1, TO + 200, "final_run");
      check("relock_saturated", 32'(relock_cnt), 32'd255);
      repeat (4) tick(1'b1);

      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pll_rst_seq
`default_nettype wire
